// File: rtl/ps2_keyboard_if.sv
// Keyboard-side and Apple 1 keyboard-register signals of the PS/2 receiver.
// The receiver uses the slave modport; the keyboard/system side uses the master modport.
interface ps2_keyboard_if;
    logic       ps2_clk;
    logic       ps2_din;
    logic       kbd_ack;
    logic [7:0] kbd_data;
    logic       kbd_valid;
    logic       frame_err;

    modport master (
        output ps2_clk, ps2_din, kbd_ack,
        input  kbd_data, kbd_valid, frame_err
    );

    modport slave (
        input  ps2_clk, ps2_din, kbd_ack,
        output kbd_data, kbd_valid, frame_err
    );
endinterface

// File: rtl/ps2_keyboard.sv
// PS/2 scancode-set-2 receiver and ASCII decoder feeding the Apple 1 keyboard latch.
// Optional macro PS2_CTRL_EN: ctrl+letter emits the control code (letter & 8'h1F).
module ps2_keyboard #(
    parameter int CLK_FREQ_HZ = 25_000_000,
    parameter int TIMEOUT_US  = 1000,
    parameter int FILTER_LEN  = 8
) (
    input  logic          clk25,
    input  logic          rst_n,
    ps2_keyboard_if.slave bus
);
    localparam int unsigned TO_MAX = (CLK_FREQ_HZ / 1_000_000) * TIMEOUT_US - 1;
    localparam int          FW     = $clog2(FILTER_LEN + 1);

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

    logic          r_clk_s1, r_clk_s2, r_din_s1, r_din_s2;
    logic          r_clk_flt, r_clk_flt_d;
    logic [FW-1:0] r_flt_cnt;
    logic          w_strobe;
    state_t        r_state;
    logic [2:0]    r_bit_cnt;
    logic [7:0]    r_sc;
    logic          r_par;
    logic [31:0]   r_to_cnt;
    logic          r_sc_stb;
    logic [7:0]    r_code;
    logic          r_frame_err;
    logic          r_brk, r_ext, r_shift_l, r_shift_r;
`ifdef PS2_CTRL_EN
    logic          r_ctrl;
`endif
    logic          r_kbd_valid;
    logic [7:0]    r_kbd_data;
    logic          w_emit;
    logic [7:0]    w_ascii;

    // Returns 8'h00 for codes with no ASCII meaning (including modifiers).
    function automatic logic [7:0] f_map(input logic [7:0] sc, input logic shift);
        logic [7:0] a;
        a = 8'h00;
        case (sc)
            8'h1C: a = 8'h41;  8'h32: a = 8'h42;  8'h21: a = 8'h43;  8'h23: a = 8'h44;
            8'h24: a = 8'h45;  8'h2B: a = 8'h46;  8'h34: a = 8'h47;  8'h33: a = 8'h48;
            8'h43: a = 8'h49;  8'h3B: a = 8'h4A;  8'h42: a = 8'h4B;  8'h4B: a = 8'h4C;
            8'h3A: a = 8'h4D;  8'h31: a = 8'h4E;  8'h44: a = 8'h4F;  8'h4D: a = 8'h50;
            8'h15: a = 8'h51;  8'h2D: a = 8'h52;  8'h1B: a = 8'h53;  8'h2C: a = 8'h54;
            8'h3C: a = 8'h55;  8'h2A: a = 8'h56;  8'h1D: a = 8'h57;  8'h22: a = 8'h58;
            8'h35: a = 8'h59;  8'h1A: a = 8'h5A;
            8'h45: a = shift ? 8'h29 : 8'h30;
            8'h16: a = shift ? 8'h21 : 8'h31;
            8'h1E: a = shift ? 8'h40 : 8'h32;
            8'h26: a = shift ? 8'h23 : 8'h33;
            8'h25: a = shift ? 8'h24 : 8'h34;
            8'h2E: a = shift ? 8'h25 : 8'h35;
            8'h36: a = shift ? 8'h5E : 8'h36;
            8'h3D: a = shift ? 8'h26 : 8'h37;
            8'h3E: a = shift ? 8'h2A : 8'h38;
            8'h46: a = shift ? 8'h28 : 8'h39;
            8'h4E: a = shift ? 8'h5F : 8'h2D;
            8'h55: a = shift ? 8'h2B : 8'h3D;
            8'h41: a = shift ? 8'h3C : 8'h2C;
            8'h49: a = shift ? 8'h3E : 8'h2E;
            8'h4A: a = shift ? 8'h3F : 8'h2F;
            8'h4C: a = shift ? 8'h3A : 8'h3B;
            8'h52: a = shift ? 8'h22 : 8'h27;
            8'h29: a = 8'h20;
            8'h5A: a = 8'h0D;
            8'h66: a = 8'h5F;
            8'h76: a = 8'h1B;
            default: a = 8'h00;
        endcase
        return a;
    endfunction

    // Synchronise both lines; the clock level only moves after FILTER_LEN agreeing samples.
    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n) begin
            r_clk_s1    <= 1'b1;
            r_clk_s2    <= 1'b1;
            r_din_s1    <= 1'b1;
            r_din_s2    <= 1'b1;
            r_clk_flt   <= 1'b1;
            r_clk_flt_d <= 1'b1;
            r_flt_cnt   <= '0;
        end else begin
            r_clk_s1    <= bus.ps2_clk;
            r_clk_s2    <= r_clk_s1;
            r_din_s1    <= bus.ps2_din;
            r_din_s2    <= r_din_s1;
            r_clk_flt_d <= r_clk_flt;
            if (r_clk_s2 == r_clk_flt) begin
                r_flt_cnt <= '0;
            end else if (r_flt_cnt == FW'(FILTER_LEN - 1)) begin
                r_clk_flt <= r_clk_s2;
                r_flt_cnt <= '0;
            end else begin
                r_flt_cnt <= r_flt_cnt + 1'b1;
            end
        end
    end

    assign w_strobe = r_clk_flt_d & ~r_clk_flt;

    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_bit_cnt   <= '0;
            r_sc        <= '0;
            r_par       <= 1'b0;
            r_to_cnt    <= '0;
            r_sc_stb    <= 1'b0;
            r_code      <= '0;
            r_frame_err <= 1'b0;
        end else begin
            r_sc_stb    <= 1'b0;
            r_frame_err <= 1'b0;
            if (r_state == S_IDLE || w_strobe)
                r_to_cnt <= '0;
            else
                r_to_cnt <= r_to_cnt + 32'd1;
            if (w_strobe) begin
                case (r_state)
                    S_IDLE: begin
                        if (!r_din_s2) begin
                            r_state   <= S_DATA;
                            r_bit_cnt <= '0;
                        end
                    end
                    S_DATA: begin
                        r_sc      <= {r_din_s2, r_sc[7:1]};
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'd7)
                            r_state <= S_PARITY;
                    end
                    S_PARITY: begin
                        r_par   <= r_din_s2;
                        r_state <= S_STOP;
                    end
                    S_STOP: begin
                        if (r_din_s2 && (^{r_sc, r_par})) begin
                            r_sc_stb <= 1'b1;
                            r_code   <= r_sc;
                        end else begin
                            r_frame_err <= 1'b1;
                        end
                        r_state <= S_IDLE;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end else if (r_state != S_IDLE && r_to_cnt == TO_MAX) begin
                r_state     <= S_IDLE;
                r_frame_err <= 1'b1;
            end
        end
    end

    // Prefix bytes and released keys never produce a character.
    always_comb begin
        w_emit  = 1'b0;
        w_ascii = 8'h00;
        if (r_sc_stb && r_code != 8'hF0 && r_code != 8'hE0 && !r_brk) begin
            if (r_ext) begin
                if (r_code == 8'h5A) begin
                    w_emit  = 1'b1;
                    w_ascii = 8'h0D;
                end
            end else begin
                w_ascii = f_map(r_code, r_shift_l | r_shift_r);
`ifdef PS2_CTRL_EN
                if (r_ctrl && w_ascii >= 8'h41 && w_ascii <= 8'h5A)
                    w_ascii = w_ascii & 8'h1F;
`endif
                w_emit = (w_ascii != 8'h00);
            end
        end
    end

    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n) begin
            r_brk       <= 1'b0;
            r_ext       <= 1'b0;
            r_shift_l   <= 1'b0;
            r_shift_r   <= 1'b0;
`ifdef PS2_CTRL_EN
            r_ctrl      <= 1'b0;
`endif
            r_kbd_valid <= 1'b0;
            r_kbd_data  <= 8'h00;
        end else begin
            if (r_sc_stb) begin
                if (r_code == 8'hF0) begin
                    r_brk <= 1'b1;
                end else if (r_code == 8'hE0) begin
                    r_ext <= 1'b1;
                end else begin
                    r_brk <= 1'b0;
                    r_ext <= 1'b0;
                    if (!r_ext && r_code == 8'h12) r_shift_l <= !r_brk;
                    if (!r_ext && r_code == 8'h59) r_shift_r <= !r_brk;
`ifdef PS2_CTRL_EN
                    if (r_code == 8'h14) r_ctrl <= !r_brk;
`endif
                end
            end
            // A new key beats a simultaneous acknowledge.
            if (w_emit) begin
                r_kbd_valid <= 1'b1;
                r_kbd_data  <= w_ascii;
            end else if (bus.kbd_ack && r_kbd_valid) begin
                r_kbd_valid <= 1'b0;
            end
        end
    end

    assign bus.kbd_data  = r_kbd_data;
    assign bus.kbd_valid = r_kbd_valid;
    assign bus.frame_err = r_frame_err;
endmodule

// File: tb/tb_ps2_keyboard.sv
// Directed bench for ps2_keyboard: drives PS/2 frames at a shortened bit period and checks the ASCII latch.
`timescale 1ns/1ps
module tb_ps2_keyboard;
    localparam int HALF = 40;  // clk25 cycles per PS/2 clock half-period
`ifdef PS2_CTRL_EN
    localparam logic [7:0] EXP_CTRL_C = 8'h03;
`else
    localparam logic [7:0] EXP_CTRL_C = 8'h43;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #20 clk = ~clk;

    ps2_keyboard_if bus();

    ps2_keyboard #(
        .CLK_FREQ_HZ(25_000_000),
        .TIMEOUT_US (10),
        .FILTER_LEN (8)
    ) dut (
        .clk25(clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int   n_cmp = 0, n_bad = 0;
    int   cyc = 0, rise_cnt = 0, rise_cyc = 0, err_cnt = 0, fall_cyc = 0;
    logic prev_valid = 1'b0;

    always @(posedge clk) begin
        #1;
        cyc++;
        if (bus.kbd_valid && !prev_valid) begin
            rise_cnt++;
            rise_cyc = cyc;
        end
        prev_valid = bus.kbd_valid;
        if (bus.frame_err) err_cnt++;
    end

    initial begin
        #(40 * 200000);
        $display("FAIL watchdog: simulation did not finish, got cycle %0d want < 200000", cyc);
        $fatal(1);
    end

    task automatic send_bit(input logic b, input int ack_at);
        @(negedge clk);
        bus.ps2_din = b;
        repeat (HALF / 2 - 1) @(negedge clk);
        bus.ps2_clk = 1'b0;
        fall_cyc = cyc;
        for (int i = 0; i < HALF; i++) begin
            @(negedge clk);
            bus.kbd_ack = (i == ack_at);
        end
        bus.kbd_ack = 1'b0;
        bus.ps2_clk = 1'b1;
        repeat (HALF / 2) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] code, input logic flip_par,
                              input logic stop, input int ack_at);
        send_bit(1'b0, -1);
        for (int i = 0; i < 8; i++) send_bit(code[i], -1);
        send_bit(~(^code) ^ flip_par, -1);
        send_bit(stop, ack_at);
        bus.ps2_din = 1'b1;
    endtask

    task automatic send_key(input logic [7:0] code);
        send_frame(code, 1'b0, 1'b1, -1);
    endtask

    task automatic send_partial(input logic [7:0] code, input int nbits);
        send_bit(1'b0, -1);
        for (int i = 0; i < nbits; i++) send_bit(code[i], -1);
        bus.ps2_din = 1'b1;
    endtask

    task automatic do_ack;
        @(negedge clk);
        bus.kbd_ack = 1'b1;
        @(negedge clk);
        bus.kbd_ack = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset;
        bus.ps2_clk = 1'b1;
        bus.ps2_din = 1'b1;
        bus.kbd_ack = 1'b0;
        rst_n = 1'b0;
        repeat (5) @(negedge clk);
        n_cmp++; if (bus.kbd_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", bus.kbd_valid); end
        n_cmp++; if (bus.kbd_data !== 8'h00) begin n_bad++; $display("FAIL reset_data: got %h want 00", bus.kbd_data); end
        n_cmp++; if (bus.frame_err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", bus.frame_err); end
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
    endtask

    task automatic test_basic;
        int e0, lat;
        e0 = err_cnt;
        send_key(8'h1C);
        lat = rise_cyc - fall_cyc;
        n_cmp++; if (bus.kbd_valid !== 1'b1) begin n_bad++; $display("FAIL basic_valid: got %b want 1", bus.kbd_valid); end
        n_cmp++; if (bus.kbd_data !== 8'h41) begin n_bad++; $display("FAIL basic_data: got %h want 41", bus.kbd_data); end
        n_cmp++; if (lat < 10 || lat > 12) begin n_bad++; $display("FAIL basic_latency: got %0d want 10..12 cycles after stop fall", lat); end
        n_cmp++; if (err_cnt !== e0) begin n_bad++; $display("FAIL basic_noerr: got %0d want %0d", err_cnt, e0); end
        do_ack;
        n_cmp++; if (bus.kbd_valid !== 1'b0) begin n_bad++; $display("FAIL ack_clear: got %b want 0", bus.kbd_valid); end
        n_cmp++; if (bus.kbd_data !== 8'h41) begin n_bad++; $display("FAIL ack_hold_data: got %h want 41", bus.kbd_data); end
        do_ack;
        n_cmp++; if (bus.kbd_valid !== 1'b0 || bus.kbd_data !== 8'h41) begin
            n_bad++; $display("FAIL idle_ack: got valid %b data %h want 0 41", bus.kbd_valid, bus.kbd_data); end
    endtask

    task automatic test_shift;
        int r0;
        r0 = rise_cnt;
        send_key(8'h12);
        send_key(8'h16);
        n_cmp++; if (bus.kbd_data !== 8'h21) begin n_bad++; $display("FAIL shift_bang: got %h want 21", bus.kbd_data); end
        n_cmp++; if (rise_cnt !== r0 + 1) begin n_bad++; $display("FAIL shift_one_emit: got %0d want %0d", rise_cnt, r0 + 1); end
        do_ack;
        send_key(8'hF0); send_key(8'h16);
        send_key(8'hF0); send_key(8'h12);
        n_cmp++; if (rise_cnt !== r0 + 1 || bus.kbd_valid !== 1'b0) begin
            n_bad++; $display("FAIL break_silent: got rises %0d valid %b want %0d 0", rise_cnt, bus.kbd_valid, r0 + 1); end
        send_key(8'h16);
        n_cmp++; if (bus.kbd_data !== 8'h31) begin n_bad++; $display("FAIL unshift_1: got %h want 31", bus.kbd_data); end
        do_ack;
        send_key(8'h59);
        send_key(8'h52);
        n_cmp++; if (bus.kbd_data !== 8'h22) begin n_bad++; $display("FAIL rshift_quote: got %h want 22", bus.kbd_data); end
        send_key(8'hF0); send_key(8'h59);
        send_key(8'h66);
        n_cmp++; if (bus.kbd_data !== 8'h5F) begin n_bad++; $display("FAIL rubout: got %h want 5F", bus.kbd_data); end
        send_key(8'h4E);
        n_cmp++; if (bus.kbd_data !== 8'h2D) begin n_bad++; $display("FAIL minus: got %h want 2D", bus.kbd_data); end
        do_ack;
    endtask

    task automatic test_frame_errors;
        int e0;
        e0 = err_cnt;
        send_frame(8'h1C, 1'b1, 1'b1, -1);
        n_cmp++; if (err_cnt !== e0 + 1) begin n_bad++; $display("FAIL parity_err: got %0d pulses want %0d", err_cnt - e0, 1); end
        n_cmp++; if (bus.kbd_valid !== 1'b0 || bus.kbd_data !== 8'h2D) begin
            n_bad++; $display("FAIL parity_noemit: got valid %b data %h want 0 2D", bus.kbd_valid, bus.kbd_data); end
        send_frame(8'h1C, 1'b0, 1'b0, -1);
        n_cmp++; if (err_cnt !== e0 + 2 || bus.kbd_valid !== 1'b0) begin
            n_bad++; $display("FAIL stop_err: got pulses %0d valid %b want 2 0", err_cnt - e0, bus.kbd_valid); end
        send_key(8'h32);
        n_cmp++; if (bus.kbd_data !== 8'h42 || bus.kbd_valid !== 1'b1) begin
            n_bad++; $display("FAIL after_err_B: got %h/%b want 42/1", bus.kbd_data, bus.kbd_valid); end
        do_ack;
    endtask

    task automatic test_timeout;
        int e0;
        e0 = err_cnt;
        send_partial(8'h5A, 3);
        repeat (400) @(negedge clk);
        n_cmp++; if (err_cnt !== e0 + 1) begin n_bad++; $display("FAIL timeout_err: got %0d pulses want 1", err_cnt - e0); end
        n_cmp++; if (bus.kbd_valid !== 1'b0) begin n_bad++; $display("FAIL timeout_noemit: got %b want 0", bus.kbd_valid); end
        send_key(8'h5A);
        n_cmp++; if (bus.kbd_data !== 8'h0D || bus.kbd_valid !== 1'b1 || err_cnt !== e0 + 1) begin
            n_bad++; $display("FAIL timeout_recover: got %h/%b/%0d want 0D/1/1", bus.kbd_data, bus.kbd_valid, err_cnt - e0); end
        do_ack;
    endtask

    task automatic test_back_to_back;
        send_key(8'h1C);
        send_key(8'h32);
        n_cmp++; if (bus.kbd_data !== 8'h42 || bus.kbd_valid !== 1'b1) begin
            n_bad++; $display("FAIL overwrite: got %h/%b want 42/1", bus.kbd_data, bus.kbd_valid); end
        send_frame(8'h21, 1'b0, 1'b1, 10);
        n_cmp++; if (bus.kbd_data !== 8'h43 || bus.kbd_valid !== 1'b1) begin
            n_bad++; $display("FAIL emit_beats_ack: got %h/%b want 43/1", bus.kbd_data, bus.kbd_valid); end
        do_ack;
        n_cmp++; if (bus.kbd_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_ack: got %b want 0", bus.kbd_valid); end
    endtask

    task automatic test_ctrl_ext;
        int r0;
        r0 = rise_cnt;
        send_key(8'h14);
        send_key(8'h21);
        n_cmp++; if (bus.kbd_data !== EXP_CTRL_C) begin n_bad++; $display("FAIL ctrl_c: got %h want %h", bus.kbd_data, EXP_CTRL_C); end
        send_key(8'hF0); send_key(8'h21);
        send_key(8'hF0); send_key(8'h14);
        n_cmp++; if (rise_cnt !== r0 + 1) begin n_bad++; $display("FAIL ctrl_one_emit: got %0d want %0d", rise_cnt - r0, 1); end
        do_ack;
        send_key(8'h21);
        n_cmp++; if (bus.kbd_data !== 8'h43) begin n_bad++; $display("FAIL ctrl_released: got %h want 43", bus.kbd_data); end
        do_ack;
        send_key(8'hE0); send_key(8'h14);
        send_key(8'h1D);
        n_cmp++; if (bus.kbd_data !== EXP_CTRL_C + 8'h14) begin
            n_bad++; $display("FAIL rctrl_w: got %h want %h", bus.kbd_data, EXP_CTRL_C + 8'h14); end
        do_ack;
        send_key(8'hE0); send_key(8'hF0); send_key(8'h14);
        send_key(8'hE0); send_key(8'h1C);
        n_cmp++; if (bus.kbd_valid !== 1'b0) begin n_bad++; $display("FAIL ext_ignored: got %b want 0", bus.kbd_valid); end
        send_key(8'hE0); send_key(8'h5A);
        n_cmp++; if (bus.kbd_data !== 8'h0D || bus.kbd_valid !== 1'b1) begin
            n_bad++; $display("FAIL kp_enter: got %h/%b want 0D/1", bus.kbd_data, bus.kbd_valid); end
        send_key(8'h1C);
        n_cmp++; if (bus.kbd_data !== 8'h41) begin n_bad++; $display("FAIL ext_cleared: got %h want 41", bus.kbd_data); end
    endtask

    task automatic test_reset_midframe;
        send_partial(8'h32, 4);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++; if (bus.kbd_valid !== 1'b0 || bus.kbd_data !== 8'h00 || bus.frame_err !== 1'b0) begin
            n_bad++; $display("FAIL midframe_reset: got %b/%h/%b want 0/00/0", bus.kbd_valid, bus.kbd_data, bus.frame_err); end
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        send_key(8'h32);
        n_cmp++; if (bus.kbd_data !== 8'h42 || bus.kbd_valid !== 1'b1) begin
            n_bad++; $display("FAIL after_reset_B: got %h/%b want 42/1", bus.kbd_data, bus.kbd_valid); end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_shift;
        test_frame_errors;
        test_timeout;
        test_back_to_back;
        test_ctrl_ext;
        test_reset_midframe;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
